// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the dmem responder.
//               - dmem_state_t : responder FSM state encoding
//               - dmem_op_t    : latched operation kind
//               - DMEM_ADDR_W / DMEM_DATA_W : default bus widths
//               - dmem_idx_w() : index width helper, never below 1 bit
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } dmem_op_t;

    // Width needed to index n items; a single item still gets one bit.
    function automatic int dmem_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response bundle between NUM_CORES L1 controllers and
//               the dmem responder.
//   req_rd_en  [NUM_CORES]          per-core read request (level)
//   req_wr_en  [NUM_CORES]          per-core write request (level)
//   req_addr   [NUM_CORES*ADDR_W]   core i at [i*ADDR_W +: ADDR_W]
//   req_wdata  [NUM_CORES*DATA_W]   core i at [i*DATA_W +: DATA_W]
//   resp_valid [NUM_CORES]          one-cycle completion pulse
//   resp_rdata [DATA_W]             read data, valid with resp_valid
//   busy                            responder in ACCESS or RESP
//   grant_id                        core currently being served
//   resp_err                        (DMEM_ERR_EN only) out-of-range access
// Modports    : master (L1 side), slave (responder side)
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = DMEM_DATA_W
);
    localparam int GRANT_W = dmem_idx_w(NUM_CORES);

    logic [NUM_CORES-1:0]        req_rd_en;
    logic [NUM_CORES-1:0]        req_wr_en;
    logic [NUM_CORES*ADDR_W-1:0] req_addr;
    logic [NUM_CORES*DATA_W-1:0] req_wdata;
    logic [NUM_CORES-1:0]        resp_valid;
    logic [DATA_W-1:0]           resp_rdata;
    logic                        busy;
    logic [GRANT_W-1:0]          grant_id;
`ifdef DMEM_ERR_EN
    logic                        resp_err;
`endif

    modport master (
        output req_rd_en, req_wr_en, req_addr, req_wdata,
`ifdef DMEM_ERR_EN
        input  resp_err,
`endif
        input  resp_valid, resp_rdata, busy, grant_id
    );

    modport slave (
        input  req_rd_en, req_wr_en, req_addr, req_wdata,
`ifdef DMEM_ERR_EN
        output resp_err,
`endif
        output resp_valid, resp_rdata, busy, grant_id
    );

endinterface
`default_nettype wire

// File: rtl/dmem_responder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Searches the request vector
//               cyclically starting at the entry after the last grant.
//   req   [N]        request vector
//   last  [idx_w(N)] index of the most recently served requester
//   grant [idx_w(N)] chosen requester (0 when none)
//   valid            at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import dmem_pkg::*;
#(
    parameter int N = 2
)(
    input  logic [N-1:0]               req,
    input  logic [dmem_idx_w(N)-1:0]   last,
    output logic [dmem_idx_w(N)-1:0]   grant,
    output logic                       valid
);
    localparam int IW = dmem_idx_w(N);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester after
    // 'last' is the one that sticks.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[IW'(idx)]) begin
                grant = IW'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Memory-side responder for NUM_CORES L1 dmem ports sharing one
//               word memory. Round-robin arbitration, fixed LATENCY cycles in
//               ACCESS, then a single-cycle resp_valid pulse to the winner.
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset (memory is not cleared)
//   bus    slave modport of dmem_responder_if (requests in, responses out)
// Options     : DMEM_ERR_EN - adds bus.resp_err, pulsed with resp_valid when
//               the latched address is >= DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 4
)(
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    localparam int GRANT_W = dmem_idx_w(NUM_CORES);
    localparam int CNT_W   = dmem_idx_w(LATENCY);
    localparam int MEM_AW  = dmem_idx_w(DEPTH);
    localparam int LIM_W   = ADDR_W + 1;
    localparam logic [LIM_W-1:0]   DEPTH_LIM = LIM_W'(DEPTH);
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [GRANT_W-1:0] PTR_INIT  = GRANT_W'(NUM_CORES - 1);

    // ------------------------------------------------------------------
    // Per-core request views
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0]    core_addr  [NUM_CORES];
    logic [DATA_W-1:0]    core_wdata [NUM_CORES];
    logic [NUM_CORES-1:0] req_any;

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
            assign core_addr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign core_wdata[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign req_any = bus.req_rd_en | bus.req_wr_en;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    dmem_state_t         state_q,  state_d;
    logic [GRANT_W-1:0]  grant_q,  grant_d;
    logic [GRANT_W-1:0]  rr_ptr_q, rr_ptr_d;
    dmem_op_t            op_q,     op_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [MEM_AW-1:0]   mem_idx;
    logic                addr_ok;

    logic [GRANT_W-1:0]  arb_grant;
    logic                arb_valid;

    rr_arbiter #(
        .N (NUM_CORES)
    ) u_arb (
        .req   (req_any),
        .last  (rr_ptr_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Out-of-range addresses never touch the array: writes vanish and
    // reads return zero.
    assign addr_ok = ({1'b0, addr_q} < DEPTH_LIM);
    assign mem_idx = addr_q[MEM_AW-1:0];

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        mem_we   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    // rd_en and wr_en together resolve to a write
                    op_d    = bus.req_wr_en[arb_grant] ? OP_WR : OP_RD;
                    addr_d  = core_addr[arb_grant];
                    wdata_d = core_wdata[arb_grant];
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                // The memory is touched only on the final ACCESS cycle, so a
                // reset before that point leaves it untouched.
                if (cnt_q == '0) begin
                    if (op_q == OP_WR) begin
                        mem_we = addr_ok;
                    end else begin
                        rdata_d = addr_ok ? mem_q[mem_idx] : '0;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            RESP: begin
                rr_ptr_d = grant_q;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= PTR_INIT;
            op_q     <= OP_RD;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
        end
    end

    // Backing store keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [NUM_CORES-1:0] resp_valid_w;

    always_comb begin
        resp_valid_w = '0;
        if (state_q == RESP) begin
            resp_valid_w[grant_q] = 1'b1;
        end
    end

    assign bus.resp_valid = resp_valid_w;
    assign bus.resp_rdata = rdata_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.grant_id   = grant_q;

`ifdef DMEM_ERR_EN
    assign bus.resp_err   = (state_q == RESP) && !addr_ok;
`endif

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the L1 cache subsystem's dmem port (rd_en / wr_en / 10-bit word address / 32-bit data).
- Serves NUM_CORES L1 controllers sharing one backing word memory, with round-robin arbitration and a fixed, configurable access latency.
- Returns a one-cycle response pulse per request. The L1 stays in stall until it sees that pulse.

Parameters:
- NUM_CORES, 2, number of L1 requesters (>=1)
- ADDR_W, 10, word-address width (matches dmem_address)
- DATA_W, 32, data word width
- DEPTH, 1024, implemented words (<= 2**ADDR_W)
- LATENCY, 4, cycles spent in ACCESS per request (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_rd_en  in  NUM_CORES  per-core read request (level)
- req_wr_en  in  NUM_CORES  per-core write request (level)
- req_addr  in  NUM_CORES*ADDR_W  per-core word address, core i at slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_CORES*DATA_W  per-core write data, same slicing
- resp_valid  out  NUM_CORES  one-cycle completion pulse to the granted core
- resp_rdata  out  DATA_W  read data, valid while resp_valid is high
- busy  out  1  high in ACCESS and RESP
- grant_id  out  $clog2(NUM_CORES) (min 1)  core currently being served

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE.
  - resp_valid=0, resp_rdata=0, busy=0, grant_id=0.
  - RR pointer points at core NUM_CORES-1, so core 0 wins first.
  - Memory contents are not cleared.
- Request protocol:
  - A core holds rd_en or wr_en, plus addr and wdata, stable until its resp_valid pulse.
  - It deasserts, or presents a new request, in the cycle after the pulse.
  - rd_en and wr_en both high is treated as a write.
- FSM IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If any core has a pending request, choose the first requester after the RR pointer (cyclic).
  - Latch grant_id, op, addr and wdata, load counter=LATENCY-1, go to ACCESS.
  - No requests: stay in IDLE.
- ACCESS:
  - Counter decrements each cycle.
  - At counter==0: a write commits to mem[addr]; a read latches mem[addr] into resp_rdata. Go to RESP.
  - Request lines are ignored in ACCESS, so changes mid-access have no effect.
- RESP:
  - resp_valid[grant_id]=1 for exactly one cycle.
  - resp_rdata holds the read data; it is held unchanged after a write.
  - RR pointer <- grant_id. Go to IDLE.
- Latency:
  - Request sampled in IDLE at edge 0; resp_valid is high in cycle LATENCY+1.
  - Minimum request-to-request spacing is LATENCY+2 cycles.
- Simultaneous requests: strict round-robin, so no core is granted twice while another core is waiting.
- Read-after-write from the other core to the same address returns the new data (writes commit before RESP).
- Address >= DEPTH: write is dropped, read returns 0 (unless DMEM_ERR_EN).
- Reset mid-operation:
  - An in-flight write that has not reached counter==0 does not commit.
  - No resp_valid is emitted; the requester re-issues after reset.
- NUM_CORES=1: arbitration degenerates; grant_id is always 0.

Optional Feature:
- DMEM_ERR_EN defined:
  - Adds output resp_err (1 bit), reset 0.
  - resp_err pulses with resp_valid when the latched addr >= DEPTH.
  - Such a write does not commit; such a read returns 0.
- DMEM_ERR_EN undefined: no resp_err port; out-of-range handling is silent as above.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, RESP} dmem_state_t
  - typedef enum logic {OP_RD, OP_WR} dmem_op_t
  - default constants for ADDR_W and DATA_W
- Sub-module rr_arbiter (parameter N) performs the combinational round-robin pick.
  - Inputs: request vector, last-grant pointer.
  - Outputs: grant index, any-valid.
- Memory array and FSM live in dmem_responder.

Test Plan:
- Single read: preload mem[0x010]=0xDEADBEEF; core0 rd_en, addr 0x010 -> resp_valid[0] high at cycle 5 (LATENCY=4), resp_rdata=0xDEADBEEF; busy high for cycles 1-5.
- Write then read: core1 writes 0x12345678 to 0x3FF, then reads 0x3FF -> second resp_rdata=0x12345678; resp_valid[0] never asserted.
- Contention: both cores request in the same cycle, continuously -> grants alternate 0,1,0,1; response pulses spaced 6 cycles apart.
- Cross-core coherence: core0 writes 0xA5A5A5A5 to 0x020 while core1 reads 0x020 in the same cycle -> core0 served first; core1 reads 0xA5A5A5A5.
- Reset mid-ACCESS: core0 writes 0x1 to 0x005 (old value 0x0), reset asserted in the 2nd ACCESS cycle -> no resp_valid; mem[0x005] still 0x0; outputs 0 immediately.
- With DMEM_ERR_EN and DEPTH=512: read addr 0x200 -> resp_valid plus resp_err together, resp_rdata=0; write addr 0x200 -> resp_err, no memory change.
